mont_mul_seq: RTL and testbench

- Sequencer for radix-2 Montgomery modular multiplication, R = A·B·2^-K mod M.
- Time-shares one (K+2)-bit cla_adder instance across three operations: partial-product add, modulus add, and final conditional subtraction.
- Sits between the operand/command interface and the Algorithm 3 datapath. Offers a start/busy/done handshake and is the only owner of the adder.

---
 rtl/mont_pkg.sv | 21 ++
 rtl/cla_adder.sv | 35 +++
 rtl/mont_mul_seq.sv | 125 ++++++++++++
 tb/tb_mont_mul_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared state encoding and width helper for the Montgomery sequencer
package mont_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ADD_B = 2'd1;
    localparam logic [STATE_W-1:0] ADD_M = 2'd2;
    localparam logic [STATE_W-1:0] SUB   = 2'd3;

    // Smallest r with 2^r >= n; sizes the bit counter so it can hold K.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_adder.sv
// rtl/cla_adder.sv - parameterised carry-lookahead adder with carry in/out
module cla_adder #(
    parameter int W = 34
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    // Each carry is expanded directly from generate/propagate terms and cin,
    // so no carry depends on another carry signal.
    always_comb begin : lookahead
        logic cj;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int j = 1; j <= W; j++) begin
            cj = cin;
            for (int k = 0; k < j; k++) begin
                cj = g[k] | (p[k] & cj);
            end
            c[j] = cj;
        end
        sum  = p ^ c[W-1:0];
        cout = c[W];
    end

endmodule

// File: rtl/mont_mul_seq.sv
// rtl/mont_mul_seq.sv - radix-2 Montgomery multiply sequencer sharing one adder (option: MONT_SKIP_ZERO_EN)
module mont_mul_seq
    import mont_pkg::*;
#(
    parameter int K = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [K-1:0] a_in,
    input  logic [K-1:0] b_in,
    input  logic [K-1:0] m_in,
    output logic         busy,
    output logic         done,
    output logic [K-1:0] r_out
);

    localparam int CW = clog2(K + 1);
    localparam int SW = K + 2;

    logic [STATE_W-1:0] state;
    logic [CW-1:0]      i;
    logic [K-1:0]       a_reg;
    logic [K-1:0]       b_reg;
    logic [K-1:0]       m_reg;
    logic [SW-1:0]      s;

    logic [SW-1:0]      add_a;
    logic [SW-1:0]      add_b;
    logic               add_cin;
    logic [SW-1:0]      sum;
    logic               cout;

    logic               a_bit;
    logic               last_bit;
    logic               do_m;

    // Current multiplier bit, last-iteration flag and whether this cycle performs the modulus step.
    always_comb begin
        a_bit    = |(a_reg & ({{(K-1){1'b0}}, 1'b1} << i));
        last_bit = (i == CW'(K - 1));
`ifdef MONT_SKIP_ZERO_EN
        do_m     = (state == ADD_M) || ((state == ADD_B) && !a_bit);
`else
        do_m     = (state == ADD_M);
`endif
    end

    // Operand/carry-in mux for the single shared adder.
    always_comb begin
        add_a   = s;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == SUB) begin
            add_b   = ~{2'b00, m_reg};
            add_cin = 1'b1;
        end else if (do_m) begin
            if (s[0]) begin
                add_b = {2'b00, m_reg};
            end
        end else if (state == ADD_B) begin
            if (a_bit) begin
                add_b = {2'b00, b_reg};
            end
        end
    end

    cla_adder #(.W(SW)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (sum),
        .cout (cout)
    );

    // Sequencer: latch operands, run K add/halve iterations, then conditionally subtract M.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            i     <= '0;
            a_reg <= '0;
            b_reg <= '0;
            m_reg <= '0;
            s     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            r_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a_in;
                        b_reg <= b_in;
                        m_reg <= m_in;
                        s     <= '0;
                        i     <= '0;
                        busy  <= 1'b1;
                        state <= ADD_B;
                    end
                end
                ADD_B, ADD_M: begin
                    if (do_m) begin
                        s     <= sum >> 1;
                        i     <= i + 1'b1;
                        state <= last_bit ? SUB : ADD_B;
                    end else begin
                        s     <= sum;
                        state <= ADD_M;
                    end
                end
                SUB: begin
                    r_out <= cout ? sum[K-1:0] : s[K-1:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_mul_seq.sv
// tb/tb_mont_mul_seq.sv - directed and swept checks of mont_mul_seq at K=8 and K=32
module tb_mont_mul_seq;

`ifdef MONT_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [7:0]  m8 = '0;
    logic        busy8;
    logic        done8;
    logic [7:0]  r8;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic [31:0] m32 = '0;
    logic        busy32;
    logic        done32;
    logic [31:0] r32;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mont_mul_seq #(.K(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a_in  (a8),
        .b_in  (b8),
        .m_in  (m8),
        .busy  (busy8),
        .done  (done8),
        .r_out (r8)
    );

    mont_mul_seq #(.K(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start32),
        .a_in  (a32),
        .b_in  (b32),
        .m_in  (m32),
        .busy  (busy32),
        .done  (done32),
        .r_out (r32)
    );

    function automatic int exp_lat(input int k, input logic [31:0] a);
        int pc;
        pc = 0;
        for (int j = 0; j < k; j++) pc += int'(a[j]);
        return SKIP ? (k + pc + 1) : (2 * k + 1);
    endfunction

    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        a8 = a; b8 = b; m8 = m; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    // Counts edges from the accepting edge until done; optionally disturbs inputs while busy.
    task automatic wait_done8(input int late_at, input bit disturb,
                              output int lat, output int bcnt, output logic [7:0] r);
        bit overlap;
        overlap = 1'b0;
        lat = 0;
        bcnt = busy8 ? 1 : 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy8 && done8) overlap = 1'b1;
            if (done8) break;
            if (busy8) bcnt++;
            if (disturb && lat == 3) begin start8 = 1'b1; a8 = ~a8; b8 = 8'd7; end
            if (disturb && lat == 4) start8 = 1'b0;
            if (late_at != 0 && lat == late_at) start8 = 1'b1;
        end
        start8 = 1'b0;
        r = r8;
        n_checks++;
        if (overlap !== 1'b0) begin n_fail++; $display("FAIL busy_done_overlap: got %0d expected 0", overlap); end
    endtask

    task automatic test_reset;
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy8: got %0b expected 0", busy8); end
        n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done8: got %0b expected 0", done8); end
        n_checks++; if (r8 !== 8'd0) begin n_fail++; $display("FAIL reset_r8: got %0d expected 0", r8); end
        n_checks++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL reset_busy32: got %0b expected 0", busy32); end
        n_checks++; if (done32 !== 1'b0) begin n_fail++; $display("FAIL reset_done32: got %0b expected 0", done32); end
        n_checks++; if (r32 !== 32'd0) begin n_fail++; $display("FAIL reset_r32: got %0d expected 0", r32); end
    endtask

    task automatic test_basic;
        int lat, bcnt;
        logic [7:0] r;
        launch8(8'd1, 8'd1, 8'd13);
        wait_done8(0, 1'b0, lat, bcnt, r);
        n_checks++; if (r !== 8'd3) begin n_fail++; $display("FAIL basic_r: got %0d expected 3", r); end
        n_checks++; if (lat != exp_lat(8, 32'd1)) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, exp_lat(8, 32'd1)); end
        n_checks++; if (bcnt != exp_lat(8, 32'd1)) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bcnt, exp_lat(8, 32'd1)); end
        @(posedge clk); #1;
        n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %0b expected 0", done8); end
    endtask

    task automatic test_vectors;
        logic [7:0] va [3] = '{8'd9, 8'd12, 8'd0};
        logic [7:0] vb [3] = '{8'd5, 8'd12, 8'd7};
        logic [7:0] vr [3] = '{8'd5, 8'd3, 8'd0};
        int lat, bcnt;
        logic [7:0] r;
        for (int n = 0; n < 3; n++) begin
            launch8(va[n], vb[n], 8'd13);
            wait_done8(0, 1'b0, lat, bcnt, r);
            n_checks++; if (r !== vr[n]) begin n_fail++; $display("FAIL vec%0d_r: got %0d expected %0d", n, r, vr[n]); end
            n_checks++; if (lat != exp_lat(8, 32'(va[n]))) begin n_fail++; $display("FAIL vec%0d_latency: got %0d expected %0d", n, lat, exp_lat(8, 32'(va[n]))); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_while_busy;
        int lat, bcnt;
        logic [7:0] r;
        launch8(8'd9, 8'd5, 8'd13);
        wait_done8(0, 1'b1, lat, bcnt, r);
        n_checks++; if (r !== 8'd5) begin n_fail++; $display("FAIL ignore_r: got %0d expected 5", r); end
        n_checks++; if (lat != exp_lat(8, 32'd9)) begin n_fail++; $display("FAIL ignore_latency: got %0d expected %0d", lat, exp_lat(8, 32'd9)); end
        @(posedge clk); #1;
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL ignore_no_queue: got %0b expected 0", busy8); end
    endtask

    task automatic test_start_at_done;
        int lat, bcnt;
        logic [7:0] r;
        launch8(8'd9, 8'd5, 8'd13);
        wait_done8(exp_lat(8, 32'd9) - 1, 1'b0, lat, bcnt, r);
        n_checks++; if (r !== 8'd5) begin n_fail++; $display("FAIL at_done_r: got %0d expected 5", r); end
        @(posedge clk); #1;
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL at_done_start_ignored: got %0b expected 0", busy8); end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        logic [7:0] r;
        launch8(8'd12, 8'd12, 8'd13);
        wait_done8(0, 1'b0, lat, bcnt, r);
        n_checks++; if (r !== 8'd3) begin n_fail++; $display("FAIL b2b_first_r: got %0d expected 3", r); end
        a8 = 8'd9; b8 = 8'd5; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL b2b_accepted: got %0b expected 1", busy8); end
        wait_done8(0, 1'b0, lat, bcnt, r);
        n_checks++; if (r !== 8'd5) begin n_fail++; $display("FAIL b2b_second_r: got %0d expected 5", r); end
        n_checks++; if (lat != exp_lat(8, 32'd9)) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", lat, exp_lat(8, 32'd9)); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat, bcnt;
        logic [7:0] r;
        launch8(8'd1, 8'd1, 8'd13);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %0b expected 0", busy8); end
        n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %0b expected 0", done8); end
        n_checks++; if (r8 !== 8'd0) begin n_fail++; $display("FAIL midreset_r: got %0d expected 0", r8); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL midreset_no_done: got %0b expected 0", done8); end
        launch8(8'd12, 8'd12, 8'd13);
        wait_done8(0, 1'b0, lat, bcnt, r);
        n_checks++; if (r !== 8'd3) begin n_fail++; $display("FAIL midreset_after_r: got %0d expected 3", r); end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep32;
        logic [31:0] a, b, m;
        longint unsigned p;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            m = $urandom | 32'd1;
            a = $urandom % m;
            b = $urandom % m;
            p = (64'(a) * 64'(b)) % 64'(m);
            for (int j = 0; j < 32; j++) begin
                if (p[0]) p = (p + 64'(m)) >> 1;
                else      p = p >> 1;
            end
            a32 = a; b32 = b; m32 = m; start32 = 1'b1;
            @(posedge clk); #1;
            start32 = 1'b0;
            lat = 0;
            while (lat < 200) begin
                @(posedge clk); #1;
                lat++;
                if (done32) break;
            end
            n_checks++; if (r32 !== p[31:0]) begin n_fail++; $display("FAIL sweep%0d_r: got %0h expected %0h", n, r32, p[31:0]); end
            n_checks++; if (lat != exp_lat(32, a)) begin n_fail++; $display("FAIL sweep%0d_latency: got %0d expected %0d", n, lat, exp_lat(32, a)); end
            @(posedge clk); #1;
            n_checks++; if (done32 !== 1'b0) begin n_fail++; $display("FAIL sweep%0d_done_width: got %0b expected 0", n, done32); end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic;
        test_vectors;
        test_ignore_while_busy;
        test_start_at_done;
        test_back_to_back;
        test_reset_mid;
        test_sweep32;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
